usb_slave_control_bi: RTL
=========================

USB_SLAVE_CONTROL_BI -- requirements
Module: usb_slave_control_bi

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: busClk and busRst_n.
REQ-002 busClk  in  1  bus and engine clock; all state updates on rising edge.
REQ-003 busRst_n  in  1  asynchronous active-low reset.
REQ-004 address  in  5  register index; dataIn  in  8  write data; writeEn  in  1  write qualifier; strobe_i  in  1  access strobe; slaveControlSelect  in  1  block select.
REQ-005 dataOut  out  8  read data.
REQ-006 transDone  in  1  one-cycle pulse from device engine; transDoneEP  in  2  endpoint index; transStatus  in  8  result; transType  in  2  SETUP/IN/OUT type.
REQ-007 NAKSent  in  1  pulse; NAKEP  in  2  endpoint index; NAKTransType  in  2  type of the NAKed token.
REQ-008 SOFRxed  in  1  pulse; frameNumIn  in  11  received frame number; resetEvent  in  1  pulse; resumeEvent  in  1  pulse; vbusDetect  in  1  asynchronous level; connectStateIn  in  2  line state.
REQ-009 epCtrl0..epCtrl3  out  5 each  {isoEn, sendStall, dataSeq, ready, enable}; deviceAddr  out  7; slaveEn  out  1; fullSpeedPol  out  1; fullSpeedRate  out  1; intOut  out  1.

Function
REQ-010 A write SHALL occur when writeEn & strobe_i & slaveControlSelect is 1 at a busClk edge.
REQ-011 Register map: 4n+0 EP_CONTROL n (R/W [4:0]); 4n+1 EP_STATUS n (RO); 4n+2 EP_TRANSTYPE n (RO [1:0]); 4n+3 EP_NAKTYPE n (RO [1:0]), n=0..3.
REQ-012 Register map cont.: 16 SC_CONTROL (R/W [2:0] {fullSpeedRate, fullSpeedPol, slaveEn}); 17 LINE_STATUS (RO {vbusSync, connectStateIn}); 18 INT_STATUS (RO, write-1-to-clear [5:0]); 19 INT_MASK (R/W [5:0]); 20 DEVICE_ADDR (R/W [6:0]); 21 FRAME_MSB (RO [2:0]); 22 FRAME_LSB (RO).
REQ-013 dataOut SHALL be a combinational mux of address, unused bits 0, unmapped addresses 8'h00; reads SHALL have no side effects.
REQ-014 On transDone, EP_STATUS[transDoneEP] <= transStatus, EP_TRANSTYPE <= transType, and that endpoint's ready bit SHALL clear on the same edge.
REQ-015 Simultaneous CPU write of EP_CONTROL and transDone on the same endpoint: CPU write value (including ready) SHALL win; status/type capture still occurs.
REQ-016 On NAKSent, EP_NAKTYPE[NAKEP] <= NAKTransType; ready unaffected.
REQ-017 On SOFRxed, frame registers SHALL capture frameNumIn on that edge.
REQ-018 vbusDetect SHALL pass through a 2-flop synchronizer (vbusSync); any vbusSync change SHALL set INT_STATUS[5].
REQ-019 INT_STATUS bits: 0 transDone, 1 resumeEvent, 2 resetEvent, 3 SOFRxed, 4 NAKSent, 5 vbus change; each set by its event, held until cleared.
REQ-020 Writing 1 to an INT_STATUS bit SHALL clear it; event set SHALL win over a simultaneous clear.
REQ-021 intOut SHALL be registered: intOut <= |(INT_STATUS & INT_MASK), one cycle after the status bit sets.
REQ-022 resetEvent SHALL clear DEVICE_ADDR to 0 and all ready bits, one edge, in addition to setting INT_STATUS[2].

Reset
REQ-023 While busRst_n=0 all registers, epCtrl0..3, deviceAddr, slaveEn, fullSpeedPol, fullSpeedRate, intOut, synchronizer flops SHALL be 0, immediately and independent of busClk.
REQ-024 Reset asserted mid-transaction SHALL discard any pending capture; first edge after deassertion behaves as from power-up.

Structure
REQ-025 A shared package SHALL hold register address constants, INT_STATUS bit positions, and epCtrl field positions.
REQ-026 One sub-module usb_slave_ep_regs SHALL implement a single endpoint's control/status set, instantiated four times.

Verification
REQ-027 Write 0x03 to addr 4 (EP1), pulse transDone EP1 status 0x41 -> epCtrl1=0x01, addr 5 reads 0x41, INT_STATUS=0x01.
REQ-028 INT_MASK=0x01, transDone pulse -> intOut=1 one cycle later; write 0x01 to addr 18 -> INT_STATUS=0x00, intOut=0 next cycle.
REQ-029 Same-edge transDone and write-1-clear of bit 0 -> INT_STATUS[0] remains 1.
REQ-030 Same-edge EP2 write 0x03 and transDone EP2 -> epCtrl2=0x03, EP_STATUS2 captured.
REQ-031 DEVICE_ADDR=0x2A, EP0 ready, pulse resetEvent -> deviceAddr=0, epCtrl0 ready=0, INT_STATUS[2]=1.
REQ-032 SOFRxed with frameNumIn=0x5A3 -> addr 21 reads 0x05, addr 22 reads 0xA3; busRst_n low mid-operation -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/usb_slave_control_bi_pkg.sv
// Shared constants for the USB slave control register block: register
// addresses, interrupt status bit positions and endpoint control fields.
package usb_slave_control_bi_pkg;

   // Per-endpoint register offsets within each 4-register group
   localparam logic [1:0] EP_OFS_CONTROL   = 2'd0;
   localparam logic [1:0] EP_OFS_STATUS    = 2'd1;
   localparam logic [1:0] EP_OFS_TRANSTYPE = 2'd2;
   localparam logic [1:0] EP_OFS_NAKTYPE   = 2'd3;

   // Global registers
   localparam logic [4:0] ADDR_SC_CONTROL  = 5'd16;
   localparam logic [4:0] ADDR_LINE_STATUS = 5'd17;
   localparam logic [4:0] ADDR_INT_STATUS  = 5'd18;
   localparam logic [4:0] ADDR_INT_MASK    = 5'd19;
   localparam logic [4:0] ADDR_DEVICE_ADDR = 5'd20;
   localparam logic [4:0] ADDR_FRAME_MSB   = 5'd21;
   localparam logic [4:0] ADDR_FRAME_LSB   = 5'd22;

   // INT_STATUS / INT_MASK bit positions
   localparam int INT_TRANS_DONE = 0;
   localparam int INT_RESUME     = 1;
   localparam int INT_RESET      = 2;
   localparam int INT_SOF        = 3;
   localparam int INT_NAK        = 4;
   localparam int INT_VBUS       = 5;

   // epCtrl field positions: {isoEn, sendStall, dataSeq, ready, enable}
   localparam int EPC_ENABLE     = 0;
   localparam int EPC_READY      = 1;
   localparam int EPC_DATA_SEQ   = 2;
   localparam int EPC_SEND_STALL = 3;
   localparam int EPC_ISO_EN     = 4;

   // Address of register 'ofs' belonging to endpoint 'ep'
   function automatic logic [4:0] ep_reg_addr(input logic [1:0] ep, input logic [1:0] ofs);
      return {1'b0, ep, ofs};
   endfunction

endpackage

// File: rtl/usb_slave_ep_regs.sv
// Control/status register set for a single USB endpoint.
module usb_slave_ep_regs
   import usb_slave_control_bi_pkg::*;
(
   input  logic       busClk,
   input  logic       busRst_n,
   input  logic       ctrl_we,
   input  logic [4:0] ctrl_wdata,
   input  logic       trans_done,
   input  logic [7:0] trans_status,
   input  logic [1:0] trans_type,
   input  logic       nak_sent,
   input  logic [1:0] nak_type,
   input  logic       usb_reset,
   output logic [4:0] ep_ctrl,
   output logic [7:0] ep_status,
   output logic [1:0] ep_trans_type,
   output logic [1:0] ep_nak_type
);

   logic [4:0] ctrl_q, ctrl_d;
   logic [7:0] status_q, status_d;
   logic [1:0] ttype_q, ttype_d;
   logic [1:0] nak_q, nak_d;

   // Next-state: CPU write beats a completed transaction's ready clear,
   // but a USB bus reset always drops ready.
   always_comb begin
      ctrl_d   = ctrl_q;
      status_d = status_q;
      ttype_d  = ttype_q;
      nak_d    = nak_q;
      if (trans_done) begin
         ctrl_d[EPC_READY] = 1'b0;
         status_d          = trans_status;
         ttype_d           = trans_type;
      end
      if (ctrl_we)
         ctrl_d = ctrl_wdata;
      if (usb_reset)
         ctrl_d[EPC_READY] = 1'b0;
      if (nak_sent)
         nak_d = nak_type;
   end

   // Endpoint state registers
   always_ff @(posedge busClk or negedge busRst_n) begin
      if (!busRst_n) begin
         ctrl_q   <= '0;
         status_q <= '0;
         ttype_q  <= '0;
         nak_q    <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         ttype_q  <= ttype_d;
         nak_q    <= nak_d;
      end
   end

   assign ep_ctrl       = ctrl_q;
   assign ep_status     = status_q;
   assign ep_trans_type = ttype_q;
   assign ep_nak_type   = nak_q;

endmodule

// File: rtl/usb_slave_control_bi.sv
// USB slave control register block: CPU-visible endpoint and device
// registers, event capture, interrupt status/mask and vbus synchronizer.
module usb_slave_control_bi
   import usb_slave_control_bi_pkg::*;
(
   input  logic        busClk,
   input  logic        busRst_n,
   input  logic [4:0]  address,
   input  logic [7:0]  dataIn,
   input  logic        writeEn,
   input  logic        strobe_i,
   input  logic        slaveControlSelect,
   output logic [7:0]  dataOut,
   input  logic        transDone,
   input  logic [1:0]  transDoneEP,
   input  logic [7:0]  transStatus,
   input  logic [1:0]  transType,
   input  logic        NAKSent,
   input  logic [1:0]  NAKEP,
   input  logic [1:0]  NAKTransType,
   input  logic        SOFRxed,
   input  logic [10:0] frameNumIn,
   input  logic        resetEvent,
   input  logic        resumeEvent,
   input  logic        vbusDetect,
   input  logic [1:0]  connectStateIn,
   output logic [4:0]  epCtrl0,
   output logic [4:0]  epCtrl1,
   output logic [4:0]  epCtrl2,
   output logic [4:0]  epCtrl3,
   output logic [6:0]  deviceAddr,
   output logic        slaveEn,
   output logic        fullSpeedPol,
   output logic        fullSpeedRate,
   output logic        intOut
);

   logic       wr_en;
   logic [4:0] ep_ctrl       [4];
   logic [7:0] ep_status     [4];
   logic [1:0] ep_trans_type [4];
   logic [1:0] ep_nak_type   [4];

   logic [2:0]  sc_control_q, sc_control_d;
   logic [5:0]  int_status_q, int_status_d;
   logic [5:0]  int_mask_q, int_mask_d;
   logic [6:0]  device_addr_q, device_addr_d;
   logic [10:0] frame_num_q, frame_num_d;
   logic        vbus_meta_q, vbus_meta_d;
   logic        vbus_sync_q, vbus_sync_d;
   logic        vbus_dly_q, vbus_dly_d;
   logic        int_out_q, int_out_d;
   logic [5:0]  int_set;
   logic [5:0]  int_clr;

   // Bit 7 of write data has no destination in any register
   logic unused_data_bit;
   assign unused_data_bit = dataIn[7];

   assign wr_en = writeEn & strobe_i & slaveControlSelect;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ep
         usb_slave_ep_regs u_ep (
            .busClk        (busClk),
            .busRst_n      (busRst_n),
            .ctrl_we       (wr_en && (address == ep_reg_addr(2'(gi), EP_OFS_CONTROL))),
            .ctrl_wdata    (dataIn[4:0]),
            .trans_done    (transDone && (transDoneEP == 2'(gi))),
            .trans_status  (transStatus),
            .trans_type    (transType),
            .nak_sent      (NAKSent && (NAKEP == 2'(gi))),
            .nak_type      (NAKTransType),
            .usb_reset     (resetEvent),
            .ep_ctrl       (ep_ctrl[gi]),
            .ep_status     (ep_status[gi]),
            .ep_trans_type (ep_trans_type[gi]),
            .ep_nak_type   (ep_nak_type[gi])
         );
      end
   endgenerate

   // Global register next-state; event set wins over write-1-to-clear
   always_comb begin
      sc_control_d  = sc_control_q;
      int_mask_d    = int_mask_q;
      device_addr_d = device_addr_q;
      frame_num_d   = frame_num_q;
      vbus_meta_d   = vbusDetect;
      vbus_sync_d   = vbus_meta_q;
      vbus_dly_d    = vbus_sync_q;
      int_clr       = '0;

      if (wr_en) begin
         case (address)
            ADDR_SC_CONTROL:  sc_control_d  = dataIn[2:0];
            ADDR_INT_STATUS:  int_clr       = dataIn[5:0];
            ADDR_INT_MASK:    int_mask_d    = dataIn[5:0];
            ADDR_DEVICE_ADDR: device_addr_d = dataIn[6:0];
            default: ;
         endcase
      end

      if (resetEvent)
         device_addr_d = '0;
      if (SOFRxed)
         frame_num_d = frameNumIn;

      int_set                 = '0;
      int_set[INT_TRANS_DONE] = transDone;
      int_set[INT_RESUME]     = resumeEvent;
      int_set[INT_RESET]      = resetEvent;
      int_set[INT_SOF]        = SOFRxed;
      int_set[INT_NAK]        = NAKSent;
      int_set[INT_VBUS]       = vbus_sync_q ^ vbus_dly_q;

      int_status_d = (int_status_q & ~int_clr) | int_set;
      int_out_d    = |(int_status_q & int_mask_q);
   end

   // Global state registers
   always_ff @(posedge busClk or negedge busRst_n) begin
      if (!busRst_n) begin
         sc_control_q  <= '0;
         int_status_q  <= '0;
         int_mask_q    <= '0;
         device_addr_q <= '0;
         frame_num_q   <= '0;
         vbus_meta_q   <= 1'b0;
         vbus_sync_q   <= 1'b0;
         vbus_dly_q    <= 1'b0;
         int_out_q     <= 1'b0;
      end else begin
         sc_control_q  <= sc_control_d;
         int_status_q  <= int_status_d;
         int_mask_q    <= int_mask_d;
         device_addr_q <= device_addr_d;
         frame_num_q   <= frame_num_d;
         vbus_meta_q   <= vbus_meta_d;
         vbus_sync_q   <= vbus_sync_d;
         vbus_dly_q    <= vbus_dly_d;
         int_out_q     <= int_out_d;
      end
   end

   // Read mux: endpoint groups below 16, global registers above
   always_comb begin
      dataOut = 8'h00;
      if (!address[4]) begin
         case (address[1:0])
            EP_OFS_CONTROL:   dataOut = {3'b000, ep_ctrl[address[3:2]]};
            EP_OFS_STATUS:    dataOut = ep_status[address[3:2]];
            EP_OFS_TRANSTYPE: dataOut = {6'b000000, ep_trans_type[address[3:2]]};
            default:          dataOut = {6'b000000, ep_nak_type[address[3:2]]};
         endcase
      end else begin
         case (address)
            ADDR_SC_CONTROL:  dataOut = {5'b00000, sc_control_q};
            ADDR_LINE_STATUS: dataOut = {5'b00000, vbus_sync_q, connectStateIn};
            ADDR_INT_STATUS:  dataOut = {2'b00, int_status_q};
            ADDR_INT_MASK:    dataOut = {2'b00, int_mask_q};
            ADDR_DEVICE_ADDR: dataOut = {1'b0, device_addr_q};
            ADDR_FRAME_MSB:   dataOut = {5'b00000, frame_num_q[10:8]};
            ADDR_FRAME_LSB:   dataOut = frame_num_q[7:0];
            default:          dataOut = 8'h00;
         endcase
      end
   end

   assign epCtrl0       = ep_ctrl[0];
   assign epCtrl1       = ep_ctrl[1];
   assign epCtrl2       = ep_ctrl[2];
   assign epCtrl3       = ep_ctrl[3];
   assign deviceAddr    = device_addr_q;
   assign slaveEn       = sc_control_q[0];
   assign fullSpeedPol  = sc_control_q[1];
   assign fullSpeedRate = sc_control_q[2];
   assign intOut        = int_out_q;

endmodule
